itch_msg_assembler: RTL and testbench
=====================================

# itch_msg_assembler

Frames a raw ITCH byte stream into whole messages for `payload_dispatcher`. Each message arrives as a 2-byte big-endian length prefix followed by the message (type byte plus body). The block strips the prefix and separates the type byte. It packs the body MSB-first into a zero-filled 512-bit payload and presents `msg_type`, `payload` and a one-cycle `out_valid`. It sits directly upstream of the dispatcher; `out_valid`, `msg_type` and `payload` connect to its `in_valid`, `msg_type` and `payload`.

## Interface
- `PAYLOAD_BYTES`, default 64: payload width in bytes. This is also the maximum body length.
- `clk`, input, 1: single clock; all logic is rising-edge.
- `rst_n`, input, 1: reset, asynchronous assert, active-low.
- `in_valid`, input, 1: `in_byte` is valid this cycle. Gaps are allowed anywhere. There is no backpressure; every valid byte is accepted.
- `in_byte`, input, 8: stream byte.
- `out_valid`, output, 1: one-cycle pulse; a message is available.
- `msg_type`, output, 8: type byte of the presented message.
- `payload`, output, `8*PAYLOAD_BYTES`: body bytes, MSB-first, zero-filled.
- `body_len`, output, 7: number of body bytes (length minus 1).
- `oversize_err`, output, 1: one-cycle pulse; a message was discarded because its length exceeded `PAYLOAD_BYTES+1`.

## Operation
States:
- `LEN_HI`: the next valid byte is the upper half of `len[15:0]`. Go to `LEN_LO`.
- `LEN_LO`: the next valid byte is the lower half.
  - If `len==0`: go to `LEN_HI`. Nothing is emitted.
  - Otherwise: go to `TYPE`.
- `TYPE`: capture the type byte and clear the accumulator to zero. Set `remaining = len-1`.
  - If `remaining==0`: emit now, with an all-zero payload and `body_len=0`.
  - Otherwise: go to `BODY`, or to `DISCARD` if `len > PAYLOAD_BYTES+1`.
- `BODY`: body byte i (0-based) is written to `acc[8*PAYLOAD_BYTES-1-8*i -: 8]`. When the last byte is accepted, emit and go to `LEN_HI`.
- `DISCARD`: count down without storing. When the last byte is accepted, pulse `oversize_err` and go to `LEN_HI`.

Emit behaviour:
- Emitting registers `msg_type`, `payload` (accumulator with the final byte merged), `body_len`, and sets `out_valid=1`.
- The output registers are separate from the accumulator. Outputs hold their values until the next emit.
- The byte counter is 7 bits. `len` is kept at 16 bits for the oversize compare. No wrap-around is possible inside `BODY`.
- `in_valid=0` in any state: no state change; counters hold.

## Timing
- Reset values: `out_valid=0`, `oversize_err=0`, `msg_type=8'h00`, `payload=0`, `body_len=0`. State is `LEN_HI` and the accumulator is 0.
- Latency: `out_valid` is high in the cycle after the final message byte is accepted.
- `oversize_err` uses the same timing.
- Back-to-back messages: the `LEN_HI` byte of the next message may be accepted in the same cycle that `out_valid` is high. Sustained throughput is one byte per cycle.
- The minimum spacing between `out_valid` pulses is 3 cycles (len=1 messages).
- `out_valid` and `oversize_err` are never high together.
- Reset asserted mid-message: everything returns to reset values immediately. The partial message is lost. The stream must restart at a length prefix after `rst_n` deasserts.

## Configuration
- `ITCH_ASM_TYPE_FILTER_EN` defined: `out_valid` is pulsed only for types `"A"`, `"X"`, `"D"` and `"U"`.
  - Other types are framed and consumed normally.
  - For those types the output registers are not updated and no pulse is produced.
- Not defined: every framed message with `len>=1` is emitted, regardless of type.

## Structure
- Shared package `itch_pkg`:
  - state enum `asm_state_t` (`LEN_HI`, `LEN_LO`, `TYPE`, `BODY`, `DISCARD`);
  - type constants `MSG_ADD="A"`, `MSG_CANCEL="X"`, `MSG_DELETE="D"`, `MSG_REPLACE="U"`;
  - `MAX_PAYLOAD_BYTES=64`.
- The dispatcher also uses these type constants.
- Single module with no sub-module. Byte-lane write enables come from a simple decode of the body index.

## Test plan
- Add order: stream `00 24 41` then 35 body bytes `01..23` → one `out_valid`, `msg_type=8'h41`, `body_len=35`, `payload[511:504]=8'h01`, `payload[239:232]=8'h23`, `payload[231:0]=0`.
- Back-to-back delete (len 19, `"D"`) then cancel (len 23, `"X"`), with no gaps → two pulses 19+2 and 23+2 cycles apart. The second payload has zeros above its last body byte.
- Random `in_valid` gaps inside a len=36 message → payload identical to the gap-free case. The pulse comes 1 cycle after the final valid byte.
- Length prefix `00 50` (80) followed by 80 bytes → `oversize_err` pulses once and there is no `out_valid`. The following valid `"D"` message is emitted correctly.
- Lengths `00 00`, then `00 01 58` → nothing for the zero length, then `out_valid` with `msg_type="X"`, `body_len=0`, `payload=0`.
- Type `"S"` (len 12): with `ITCH_ASM_TYPE_FILTER_EN`, no pulse and outputs unchanged; without it, a pulse occurs. Then `rst_n` low mid-way through a second message → all outputs 0 and the next framed message is emitted normally.

Source files
------------

// File: rtl/itch_pkg.sv
// Shared ITCH definitions: assembler state encoding, message type codes, payload limit.
package itch_pkg;

  typedef enum logic [2:0] {
    LEN_HI,
    LEN_LO,
    TYPE,
    BODY,
    DISCARD
  } asm_state_t;

  localparam logic [7:0] MSG_ADD     = 8'h41;  // "A"
  localparam logic [7:0] MSG_CANCEL  = 8'h58;  // "X"
  localparam logic [7:0] MSG_DELETE  = 8'h44;  // "D"
  localparam logic [7:0] MSG_REPLACE = 8'h55;  // "U"

  localparam int unsigned MAX_PAYLOAD_BYTES = 64;

endpackage

// File: rtl/itch_msg_assembler_if.sv
// Byte-stream input and framed-message output of the ITCH message assembler.
interface itch_msg_assembler_if #(
  parameter int unsigned PAYLOAD_BYTES = 64
);
  logic                       in_valid;
  logic [7:0]                 in_byte;
  logic                       out_valid;
  logic [7:0]                 msg_type;
  logic [8*PAYLOAD_BYTES-1:0] payload;
  logic [6:0]                 body_len;
  logic                       oversize_err;

  modport master (
    output in_valid, in_byte,
    input  out_valid, msg_type, payload, body_len, oversize_err
  );

  modport slave (
    input  in_valid, in_byte,
    output out_valid, msg_type, payload, body_len, oversize_err
  );
endinterface

// File: rtl/itch_msg_assembler.sv
// Frames length-prefixed ITCH messages into type + MSB-first zero-filled payload.
// Optional: ITCH_ASM_TYPE_FILTER_EN restricts emitted messages to types A/X/D/U.
module itch_msg_assembler
  import itch_pkg::*;
#(
  parameter int unsigned PAYLOAD_BYTES = MAX_PAYLOAD_BYTES
) (
  input logic                  clk,
  input logic                  rst_n,
  itch_msg_assembler_if.slave  bus
);

  localparam int unsigned W = 8 * PAYLOAD_BYTES;

  asm_state_t   state_q, state_d;
  logic [15:0]  len_q, len_d;
  logic [6:0]   idx_q, idx_d;
  logic [7:0]   type_q, type_d;
  logic [W-1:0] acc_q, acc_d;

  logic         out_valid_q, out_valid_d;
  logic         oversize_q, oversize_d;
  logic [7:0]   msg_type_q, msg_type_d;
  logic [W-1:0] payload_q, payload_d;
  logic [6:0]   body_len_q, body_len_d;

  logic [W-1:0] acc_merged;
  logic [7:0]   cand_type;
  logic         type_ok;

  // Accumulator with the current byte dropped into the lane selected by the body index.
  always_comb begin
    acc_merged = acc_q;
    for (int unsigned j = 0; j < PAYLOAD_BYTES; j++) begin
      if (idx_q == 7'(j)) begin
        acc_merged[W-1-8*j -: 8] = bus.in_byte;
      end
    end
  end

  assign cand_type = (state_q == TYPE) ? bus.in_byte : type_q;

`ifdef ITCH_ASM_TYPE_FILTER_EN
  assign type_ok = cand_type inside {MSG_ADD, MSG_CANCEL, MSG_DELETE, MSG_REPLACE};
`else
  assign type_ok = 1'b1;
`endif

  always_comb begin
    state_d     = state_q;
    len_d       = len_q;
    idx_d       = idx_q;
    type_d      = type_q;
    acc_d       = acc_q;
    out_valid_d = 1'b0;
    oversize_d  = 1'b0;
    msg_type_d  = msg_type_q;
    payload_d   = payload_q;
    body_len_d  = body_len_q;

    if (bus.in_valid) begin
      unique case (state_q)
        LEN_HI: begin
          len_d   = {bus.in_byte, 8'h00};
          state_d = LEN_LO;
        end
        LEN_LO: begin
          len_d   = {len_q[15:8], bus.in_byte};
          state_d = ({len_q[15:8], bus.in_byte} == 16'd0) ? LEN_HI : TYPE;
        end
        TYPE: begin
          type_d = bus.in_byte;
          acc_d  = '0;
          idx_d  = '0;
          len_d  = len_q - 16'd1;  // len_q now counts remaining body bytes
          if (len_q == 16'd1) begin
            state_d = LEN_HI;
            if (type_ok) begin
              out_valid_d = 1'b1;
              msg_type_d  = cand_type;
              payload_d   = '0;
              body_len_d  = '0;
            end
          end else if (len_q > 16'(PAYLOAD_BYTES + 1)) begin
            state_d = DISCARD;
          end else begin
            state_d = BODY;
          end
        end
        BODY: begin
          acc_d = acc_merged;
          idx_d = idx_q + 7'd1;
          len_d = len_q - 16'd1;
          if (len_q == 16'd1) begin
            state_d = LEN_HI;
            if (type_ok) begin
              out_valid_d = 1'b1;
              msg_type_d  = cand_type;
              payload_d   = acc_merged;
              body_len_d  = idx_q + 7'd1;
            end
          end
        end
        DISCARD: begin
          len_d = len_q - 16'd1;
          if (len_q == 16'd1) begin
            state_d    = LEN_HI;
            oversize_d = 1'b1;
          end
        end
        default: state_d = LEN_HI;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= LEN_HI;
      len_q       <= '0;
      idx_q       <= '0;
      type_q      <= '0;
      acc_q       <= '0;
      out_valid_q <= 1'b0;
      oversize_q  <= 1'b0;
      msg_type_q  <= '0;
      payload_q   <= '0;
      body_len_q  <= '0;
    end else begin
      state_q     <= state_d;
      len_q       <= len_d;
      idx_q       <= idx_d;
      type_q      <= type_d;
      acc_q       <= acc_d;
      out_valid_q <= out_valid_d;
      oversize_q  <= oversize_d;
      msg_type_q  <= msg_type_d;
      payload_q   <= payload_d;
      body_len_q  <= body_len_d;
    end
  end

  assign bus.out_valid    = out_valid_q;
  assign bus.oversize_err = oversize_q;
  assign bus.msg_type     = msg_type_q;
  assign bus.payload      = payload_q;
  assign bus.body_len     = body_len_q;

endmodule

// File: tb/tb_itch_msg_assembler.sv
// Randomized self-checking bench for itch_msg_assembler against a message-level model.
module tb_itch_msg_assembler;
  import itch_pkg::*;

  localparam int unsigned PB = 64;
  localparam int unsigned W  = 8 * PB;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  itch_msg_assembler_if #(.PAYLOAD_BYTES(PB)) bus ();

  itch_msg_assembler #(.PAYLOAD_BYTES(PB)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    bit           ovf;
    logic [7:0]   typ;
    logic [W-1:0] pay;
    logic [6:0]   blen;
    longint       due;
  } ev_t;

  ev_t          evq[$];
  longint       out_cyc[$];
  logic [7:0]   bq[$];
  longint       cyc = 0;
  int           n_checks = 0;
  int           n_fail = 0;
  int           n_out = 0;
  int           n_ovf = 0;
  int           gap_pct = 0;
  logic [7:0]   m_type = '0;
  logic [W-1:0] m_pay = '0;
  logic [6:0]   m_blen = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
    end
  endtask

  // Per-cycle comparison of every output against the message-level model.
  initial begin : compare
    ev_t e;
    bit  e_out, e_ovf;
    forever begin
      @(negedge clk);
      e_out = 1'b0;
      e_ovf = 1'b0;
      if (!rst_n) begin
        m_type = '0;
        m_pay  = '0;
        m_blen = '0;
        evq.delete();
      end else begin
        while (evq.size() > 0 && evq[0].due < cyc) begin
          e = evq.pop_front();
          check("missed_event", 1'b0, 1'b1);
        end
        if (evq.size() > 0 && evq[0].due == cyc) begin
          e = evq.pop_front();
          if (e.ovf) e_ovf = 1'b1;
          else begin
            e_out  = 1'b1;
            m_type = e.typ;
            m_pay  = e.pay;
            m_blen = e.blen;
          end
        end
      end
      check("out_valid", bus.out_valid, e_out);
      check("oversize_err", bus.oversize_err, e_ovf);
      check("msg_type", bus.msg_type, m_type);
      check("body_len", bus.body_len, m_blen);
      check("payload", bus.payload, m_pay);
      if (bus.out_valid === 1'b1) begin
        n_out++;
        out_cyc.push_back(cyc);
      end
      if (bus.oversize_err === 1'b1) n_ovf++;
    end
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      bus.in_valid = 1'b0;
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    if (gap_pct > 0) begin
      while ($urandom_range(99) < gap_pct) begin
        @(negedge clk);
        bus.in_valid = 1'b0;
      end
    end
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_byte  = b;
    @(posedge clk);
    #1;
  endtask

  // Sends prefix, type and bq as body; the expected result follows from len alone.
  task automatic send_msg(input int len, input logic [7:0] typ);
    ev_t e;
    bit  pass;
    logic [15:0] l16;
    l16 = 16'(len);
    send_byte(l16[15:8]);
    send_byte(l16[7:0]);
    if (len == 0) return;
    send_byte(typ);
    for (int i = 0; i < len - 1; i++) send_byte(bq[i]);
    e.due  = cyc;
    e.typ  = typ;
    e.blen = 7'(len - 1);
    e.pay  = '0;
    e.ovf  = (len - 1 > int'(PB));
    if (!e.ovf) for (int i = 0; i < len - 1; i++) e.pay[W-1-8*i -: 8] = bq[i];
    pass = 1'b1;
`ifdef ITCH_ASM_TYPE_FILTER_EN
    pass = typ inside {8'h41, 8'h58, 8'h44, 8'h55};
`endif
    if (e.ovf || pass) evq.push_back(e);
  endtask

  task automatic fill_seq(input int n);
    bq.delete();
    for (int i = 0; i < n; i++) bq.push_back(8'(i + 1));
  endtask

  task automatic fill_rand(input int n);
    bq.delete();
    for (int i = 0; i < n; i++) bq.push_back(8'h80 | 8'($urandom));
  endtask

  initial begin : stim
    int           n0, v0, c0, len;
    logic [W-1:0] exp_pay;
    logic [7:0]   tlist [6];
    logic [7:0]   typ;
    tlist = '{8'h41, 8'h58, 8'h44, 8'h55, 8'h53, 8'h45};
    bus.in_valid = 1'b0;
    bus.in_byte  = '0;

    // Reset state
    idle(3);
    check("rst_out_valid", bus.out_valid, 1'b0);
    check("rst_payload", bus.payload, '0);
    check("rst_msg_type", bus.msg_type, 8'h00);
    @(negedge clk);
    rst_n = 1'b1;
    idle(2);

    // Add order, len 36, body 01..23
    n0 = n_out;
    fill_seq(35);
    send_msg(36, 8'h41);
    idle(2);
    check("add_pulses", 32'(n_out - n0), 32'd1);
    check("add_type", bus.msg_type, 8'h41);
    check("add_len", bus.body_len, 7'd35);
    check("add_first", bus.payload[511:504], 8'h01);
    check("add_last", bus.payload[239:232], 8'h23);
    check("add_tail_zero", bus.payload[231:0], '0);

    // Back-to-back D(19), D(19), X(23)
    c0 = out_cyc.size();
    fill_rand(22);
    send_msg(19, 8'h44);
    send_msg(19, 8'h44);
    send_msg(23, 8'h58);
    idle(2);
    check("b2b_pulses", 32'(out_cyc.size() - c0), 32'd3);
    if (out_cyc.size() - c0 == 3) begin
      check("b2b_gap_d", 32'(out_cyc[c0+1] - out_cyc[c0]), 32'd21);
      check("b2b_gap_x", 32'(out_cyc[c0+2] - out_cyc[c0+1]), 32'd25);
    end
    check("b2b_x_tail", bus.payload[335:0], '0);

    // Same add order with random gaps
    gap_pct = 40;
    fill_seq(35);
    send_msg(36, 8'h41);
    gap_pct = 0;
    idle(2);
    exp_pay = '0;
    for (int i = 0; i < 35; i++) exp_pay[W-1-8*i -: 8] = 8'(i + 1);
    check("gap_payload", bus.payload, exp_pay);

    // Oversize 80, then a valid delete
    n0 = n_out;
    v0 = n_ovf;
    fill_rand(79);
    send_msg(80, 8'h41);
    idle(2);
    check("ovf_pulses", 32'(n_ovf - v0), 32'd1);
    check("ovf_no_out", 32'(n_out - n0), 32'd0);
    fill_rand(4);
    send_msg(5, 8'h44);
    idle(2);
    check("after_ovf_type", bus.msg_type, 8'h44);

    // Boundary: 64-byte body emits, 65-byte body discards
    fill_rand(65);
    send_msg(65, 8'h55);
    v0 = n_ovf;
    send_msg(66, 8'h55);
    idle(2);
    check("edge66_ovf", 32'(n_ovf - v0), 32'd1);

    // Zero length, then len 1 "X"
    n0 = n_out;
    send_msg(0, 8'h00);
    send_msg(1, 8'h58);
    idle(2);
    check("len1_pulses", 32'(n_out - n0), 32'd1);
    check("len1_type", bus.msg_type, 8'h58);
    check("len1_blen", bus.body_len, 7'd0);
    check("len1_payload", bus.payload, '0);

    // Type "S", len 12
    n0 = n_out;
    fill_rand(11);
    send_msg(12, 8'h53);
    idle(2);
`ifdef ITCH_ASM_TYPE_FILTER_EN
    check("s_pulses", 32'(n_out - n0), 32'd0);
    check("s_type", bus.msg_type, 8'h58);
`else
    check("s_pulses", 32'(n_out - n0), 32'd1);
    check("s_type", bus.msg_type, 8'h53);
`endif

    // Reset mid-message
    send_byte(8'h00);
    send_byte(8'h0A);
    send_byte(8'h41);
    send_byte(8'h11);
    send_byte(8'h22);
    #1;
    rst_n = 1'b0;
    bus.in_valid = 1'b0;
    #1;
    check("midrst_type", bus.msg_type, 8'h00);
    check("midrst_payload", bus.payload, '0);
    idle(2);
    rst_n = 1'b1;
    idle(1);
    fill_rand(9);
    send_msg(10, 8'h41);
    idle(2);
    check("post_rst_type", bus.msg_type, 8'h41);

    // Random traffic
    for (int k = 0; k < 40; k++) begin
      int r;
      r = int'($urandom_range(9));
      if (r == 0) len = 0;
      else if (r == 1) len = 1;
      else if (r == 2) len = int'($urandom_range(80, 66));
      else len = int'($urandom_range(65, 2));
      if ($urandom_range(6) == 0) typ = 8'($urandom);
      else typ = tlist[$urandom_range(5)];
      gap_pct = ($urandom_range(1) == 1) ? 30 : 0;
      bq.delete();
      for (int i = 0; i < 80; i++) bq.push_back(8'($urandom));
      send_msg(len, typ);
    end
    gap_pct = 0;
    idle(5);
    check("queue_drained", 32'(evq.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
